// File: rtl/c4_pkg.sv
// Shared connect-four definitions: board geometry, cell codes, controller states
// and the grid cell accessor used by the win/draw scan.
package c4_pkg;

  localparam int ROWS   = 6;
  localparam int COLS   = 7;
  localparam int CELL_W = 2;
  localparam int GRID_W = 98;
  localparam int CELLS  = ROWS * COLS;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] P0    = 2'd1;
  localparam logic [1:0] P1    = 2'd2;

  typedef enum logic [2:0] {PLAY, SETTLE, SCAN, WIN, DRAW} state_t;

  // MSB of board cell (r, c); row 0 is the bottom row, the selector row sits above row 5.
  function automatic int cell_idx(input int r, input int c);
    return COLS * CELL_W * r + COLS * CELL_W - 1 - CELL_W * c;
  endfunction

  // Off-board coordinates read as EMPTY so line checks never match past an edge.
  function automatic logic [1:0] cell_at(input logic [GRID_W-1:0] g, input int r, input int c);
    logic [GRID_W-1:0] s;
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return EMPTY;
    s = g >> (cell_idx(r, c) - 1);
    return s[1:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchroniser, stability counter and rising-edge detector
// producing a single-cycle press pulse per accepted press.
module btn_debounce
  import c4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES);

  logic            sync_q1, sync_q2;
  logic            db_lvl, db_lvl_q;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      cnt      <= '0;
      db_lvl   <= 1'b0;
      db_lvl_q <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      // sync_q1 != sync_q2 means the synced level changes on this edge
      if (sync_q1 != sync_q2) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (cnt == CNT_MAX) db_lvl <= sync_q2;
      db_lvl_q <= db_lvl;
    end
  end

  assign press = db_lvl & ~db_lvl_q;

endmodule

// File: rtl/game_ctrl.sv
// Connect-four sequencer: debounced buttons become move pulses while playing,
// and each drop triggers a cell-by-cell scan for four-in-a-row or a full board.
module game_ctrl
  import c4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_mid,
  input  logic [GRID_W-1:0] grid,
  output logic              left_o,
  output logic              right_o,
  output logic              drop_o,
  output logic              new_game,
  output logic              busy,
  output logic              game_over,
  output logic              winner,
  output logic              draw
);

  localparam logic [5:0] LAST_IDX = 6'(CELLS - 1);

  logic [1:0] rst_sync;
  logic       rst_i_n;
  logic       press_l, press_r, press_m;
  state_t     state, state_nxt;
  logic [5:0] idx, idx_nxt;
  logic       winner_q, winner_nxt;
  logic [2:0] scan_r, scan_c;
  logic [1:0] cur_v;
  logic       hit, row5_full;

  // Assert immediately, release two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_left (
    .clk(clk), .rst_n(rst_i_n), .btn(btn_left), .press(press_l));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_right (
    .clk(clk), .rst_n(rst_i_n), .btn(btn_right), .press(press_r));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_mid (
    .clk(clk), .rst_n(rst_i_n), .btn(btn_mid), .press(press_m));

  function automatic logic run4(input logic [GRID_W-1:0] g, input int r, input int c,
                                input int dr, input int dc, input logic [1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 1; k < 4; k++)
      if (cell_at(g, r + k * dr, c + k * dc) != v) ok = 1'b0;
    return ok;
  endfunction

  // Window compare for the cell under idx, looking only up and to the sides.
  always_comb begin
    scan_r = 3'(idx / 6'd7);
    scan_c = 3'(idx % 6'd7);
    cur_v  = cell_at(grid, int'(scan_r), int'(scan_c));
    hit    = 1'b0;
    if (cur_v != EMPTY) begin
      if (scan_c <= 3'd3 && run4(grid, int'(scan_r), int'(scan_c), 0, 1, cur_v))
        hit = 1'b1;
      if (scan_r <= 3'd2 && run4(grid, int'(scan_r), int'(scan_c), 1, 0, cur_v))
        hit = 1'b1;
      if (scan_r <= 3'd2 && scan_c <= 3'd3 && run4(grid, int'(scan_r), int'(scan_c), 1, 1, cur_v))
        hit = 1'b1;
      if (scan_r <= 3'd2 && scan_c >= 3'd3 && run4(grid, int'(scan_r), int'(scan_c), 1, -1, cur_v))
        hit = 1'b1;
    end
    row5_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (cell_at(grid, ROWS - 1, c) == EMPTY) row5_full = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state    <= PLAY;
      idx      <= '0;
      winner_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      winner_q <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    winner_nxt = winner_q;
    left_o     = 1'b0;
    right_o    = 1'b0;
    drop_o     = 1'b0;
    new_game   = 1'b0;
    case (state)
      PLAY: begin
        if (press_l)      left_o  = 1'b1;
        else if (press_r) right_o = 1'b1;
        else if (press_m) begin
          drop_o    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        state_nxt = SCAN;
        idx_nxt   = '0;
      end
      SCAN: begin
        if (hit) begin
          state_nxt  = WIN;
          winner_nxt = (cur_v == P1);
        end else if (idx == LAST_IDX) begin
          state_nxt = row5_full ? DRAW : PLAY;
        end else begin
          idx_nxt = idx + 6'd1;
        end
      end
      WIN, DRAW: begin
        if (press_m) begin
          new_game   = 1'b1;
          winner_nxt = 1'b0;
          state_nxt  = PLAY;
        end
      end
      default: state_nxt = PLAY;
    endcase
  end

  assign busy      = (state == SETTLE) || (state == SCAN);
  assign game_over = (state == WIN) || (state == DRAW);
  assign draw      = (state == DRAW);
  assign winner    = winner_q;

endmodule
